// File: rtl/agu_split_pkg.sv
// agu_split_pkg: types shared by the address-generation/split unit and its
// neighbours.
//   - lsu_op_e        LSU opcodes seen by the AGU
//   - agu_exc_e       exception codes produced by the AGU
//   - BranchProv      branch/flush broadcast
//   - EX_UOp          load/store uop entering the AGU
//   - AGU_SPLIT_UOp   address-generated uop leaving towards the LSU
// Address/data fields are sized for the widest configuration (64 bits). A
// 32-bit instance uses the low half and drives the upper bits to zero.
package agu_split_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int WMASK_MAX = XLEN_MAX / 8;
    localparam int SQN_W     = 7;
    localparam int TAG_W     = 7;
    localparam int NM_W      = 5;
    localparam int PC_W      = 32;

    typedef enum logic [3:0] {
        LSU_LB, LSU_LH, LSU_LW, LSU_LD,
        LSU_LBU, LSU_LHU, LSU_LWU, LSU_FLW,
        LSU_SB, LSU_SH, LSU_SW, LSU_SD, LSU_FSW
    } lsu_op_e;

    typedef enum logic [1:0] {
        EXC_NONE, EXC_NULLPTR, EXC_MISALIGNED, EXC_ILLEGAL
    } agu_exc_e;

    typedef enum logic {
        ST_IDLE, ST_SECOND
    } split_state_e;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;

    typedef struct packed {
        logic                valid;
        logic [XLEN_MAX-1:0] srcA;
        logic [XLEN_MAX-1:0] srcB;
        logic [11:0]         imm;
        lsu_op_e             opcode;
        logic [PC_W-1:0]     pc;
        logic [TAG_W-1:0]    tagDst;
        logic [NM_W-1:0]     nmDst;
        logic [SQN_W-1:0]    sqN;
        logic [SQN_W-1:0]    storeSqN;
        logic [SQN_W-1:0]    loadSqN;
        logic                compressed;
    } EX_UOp;

    typedef struct packed {
        logic                 valid;
        logic [XLEN_MAX-1:0]  addr;
        logic [XLEN_MAX-1:0]  data;
        logic [WMASK_MAX-1:0] wmask;
        logic [2:0]           shamt;
        logic [1:0]           size;
        logic                 signExtend;
        logic                 isLoad;
        logic                 part;
        logic                 split;
        agu_exc_e             exception;
        logic [PC_W-1:0]      pc;
        logic [TAG_W-1:0]     tagDst;
        logic [NM_W-1:0]      nmDst;
        logic [SQN_W-1:0]     sqN;
        logic [SQN_W-1:0]     storeSqN;
        logic [SQN_W-1:0]     loadSqN;
        logic                 compressed;
    } AGU_SPLIT_UOp;

    // log2 of the access size in bytes.
    function automatic logic [1:0] op_size(input lsu_op_e op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: op_size = 2'd0;
            LSU_LH, LSU_LHU, LSU_SH: op_size = 2'd1;
            LSU_LD, LSU_SD:          op_size = 2'd3;
            default:                 op_size = 2'd2;
        endcase
    endfunction

    function automatic logic op_is_load(input lsu_op_e op);
        return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD,
                          LSU_LBU, LSU_LHU, LSU_LWU, LSU_FLW};
    endfunction

    function automatic logic op_sign_ext(input lsu_op_e op);
        return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LD};
    endfunction

endpackage

// File: rtl/agu_split_lanes.sv
// agu_lanes: byte-lane generation for one access.
//   size      in   log2 of access bytes
//   offset    in   byte offset of the address inside an XLEN word
//   data      in   store data, right-aligned
//   crossing  out  access runs past the end of the XLEN word
//   wmask_p0  out  byte mask of the lanes inside the first word
//   data_p0   out  data shifted left into the first word
//   wmask_p1  out  byte mask of the lanes spilling into the next word
//   data_p1   out  data shifted right into the next word
// A non-crossing access has wmask_p1 == 0 and uses only the p0 outputs.
module agu_lanes
    import agu_split_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int NB   = XLEN / 8,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [1:0]      size,
    input  logic [OFFW-1:0] offset,
    input  logic [XLEN-1:0] data,
    output logic            crossing,
    output logic [NB-1:0]   wmask_p0,
    output logic [XLEN-1:0] data_p0,
    output logic [NB-1:0]   wmask_p1,
    output logic [XLEN-1:0] data_p1
);

    logic [3:0]        bytes;
    logic [2*NB-1:0]   one_wide;
    logic [2*NB-1:0]   mask_full;
    logic [2*NB-1:0]   mask_wide;
    logic [2*XLEN-1:0] data_wide;

    // Shifting into a double-width word gives both parts at once: the low
    // half lands in the addressed word, the high half in the next one.
    // NOTE: every variable assigned here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        bytes     = 4'd1 << size;
        one_wide  = '0;
        one_wide[0] = 1'b1;
        mask_full = (one_wide << bytes) - one_wide;
        mask_wide = mask_full << offset;
        data_wide = {{XLEN{1'b0}}, data} << {offset, 3'b000};
        crossing  = (int'(offset) + int'(bytes)) > NB;
        wmask_p0  = mask_wide[NB-1:0];
        wmask_p1  = mask_wide[2*NB-1:NB];
        data_p0   = data_wide[XLEN-1:0];
        data_p1   = data_wide[2*XLEN-1:XLEN];
    end

endmodule

// File: rtl/agu_split.sv
// agu_split: address generation for loads/stores with optional splitting of
// accesses that cross an XLEN word boundary into two aligned uops.
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   en         in   unit enable
//   IN_branch  in   branch/flush broadcast
//   IN_uop     in   load/store uop
//   OUT_ready  out  IN_uop accepted this cycle
//   IN_ready   in   downstream LSU takes OUT_uop this cycle
//   OUT_uop    out  registered address-generated uop
// Parameters: XLEN (32/64), SPLIT_EN (split vs. misaligned trap),
// NULL_TRAP (trap on address 0).
module agu_split
    import agu_split_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int SPLIT_EN  = 1,
    parameter int NULL_TRAP = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  BranchProv    IN_branch,
    input  EX_UOp        IN_uop,
    output logic         OUT_ready,
    input  logic         IN_ready,
    output AGU_SPLIT_UOp OUT_uop
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    logic [XLEN-1:0]  src_a, src_b, imm_sext, addr, addr_aligned;
    logic [OFFW-1:0]  offset;
    logic [1:0]       size;
    logic             misaligned, crossing, do_split;
    logic             flush_in, flush_out, accept;
    logic [SQN_W-1:0] age_in, age_out;
    agu_exc_e         exc;
    logic [NB-1:0]    wmask_p0, wmask_p1;
    logic [XLEN-1:0]  data_p0, data_p1;
    AGU_SPLIT_UOp     new_uop, out_d, out_q;
    split_state_e     state_d, state_q;
    logic [XLEN-1:0]  p1_addr_d, p1_addr_q, p1_data_d, p1_data_q;
    logic [NB-1:0]    p1_wmask_d, p1_wmask_q;
    logic             unused_bits;

    assign unused_bits  = ^{IN_uop.srcA, IN_uop.srcB};
    assign src_a        = IN_uop.srcA[XLEN-1:0];
    assign src_b        = IN_uop.srcB[XLEN-1:0];
    assign imm_sext     = {{(XLEN-12){IN_uop.imm[11]}}, IN_uop.imm};
    assign addr         = src_a + imm_sext;
    assign addr_aligned = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign offset       = addr[OFFW-1:0];
    assign size         = op_size(IN_uop.opcode);

    agu_lanes #(.XLEN(XLEN)) u_lanes (
        .size     (size),
        .offset   (offset),
        .data     (src_b),
        .crossing (crossing),
        .wmask_p0 (wmask_p0),
        .data_p0  (data_p0),
        .wmask_p1 (wmask_p1),
        .data_p1  (data_p1)
    );

    always_comb begin
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = addr[0];
            2'd2:    misaligned = |addr[1:0];
            default: misaligned = |addr[2:0];
        endcase
    end

    always_comb begin
        exc = EXC_NONE;
        if (size == 2'd3 && XLEN == 32)
            exc = EXC_ILLEGAL;
        else if (NULL_TRAP != 0 && addr == '0)
            exc = EXC_NULLPTR;
        else if (SPLIT_EN == 0 && misaligned)
            exc = EXC_MISALIGNED;
    end

    // A crossing access is always misaligned, so with SPLIT_EN=0 it already
    // carries an exception and never reaches the split path.
    assign do_split = (SPLIT_EN != 0) && crossing && (exc == EXC_NONE);

    // A uop is younger than the branch (and flushed) when the wrapped
    // difference sqN - branch.sqN is strictly positive in two's complement.
    assign age_in    = IN_uop.sqN - IN_branch.sqN;
    assign age_out   = out_q.sqN - IN_branch.sqN;
    assign flush_in  = IN_branch.taken && !age_in[SQN_W-1] && (age_in != '0);
    assign flush_out = out_q.valid && IN_branch.taken &&
                       !age_out[SQN_W-1] && (age_out != '0);

    // rst gates the handshake directly so OUT_ready is low for the whole
    // reset window, not only after the first clock edge.
    assign accept = rst && en && IN_uop.valid && (state_q == ST_IDLE) &&
                    (!out_q.valid || IN_ready) && !flush_in;

    assign OUT_ready = accept;
    assign OUT_uop   = out_q;

    always_comb begin
        new_uop            = '0;
        new_uop.valid      = 1'b1;
        new_uop.addr[XLEN-1:0]  = do_split ? addr_aligned : addr;
        new_uop.data[XLEN-1:0]  = data_p0;
        new_uop.wmask[NB-1:0]   = (exc == EXC_NONE) ? wmask_p0 : '0;
        new_uop.shamt[OFFW-1:0] = offset;
        new_uop.size       = size;
        new_uop.signExtend = op_sign_ext(IN_uop.opcode);
        new_uop.isLoad     = op_is_load(IN_uop.opcode);
        new_uop.part       = 1'b0;
        new_uop.split      = do_split;
        new_uop.exception  = exc;
        new_uop.pc         = IN_uop.pc;
        new_uop.tagDst     = IN_uop.tagDst;
        new_uop.nmDst      = IN_uop.nmDst;
        new_uop.sqN        = IN_uop.sqN;
        new_uop.storeSqN   = IN_uop.storeSqN;
        new_uop.loadSqN    = IN_uop.loadSqN;
        new_uop.compressed = IN_uop.compressed;
    end

    // Part 1 reuses the pass-through fields of part 0 still sitting in the
    // output register; only address, mask, data and part change.
    always_comb begin
        out_d      = out_q;
        state_d    = state_q;
        p1_addr_d  = p1_addr_q;
        p1_data_d  = p1_data_q;
        p1_wmask_d = p1_wmask_q;

        if (out_q.valid && IN_ready)
            out_d.valid = 1'b0;
        if (flush_out)
            out_d.valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    out_d = new_uop;
                    if (do_split) begin
                        state_d    = ST_SECOND;
                        p1_addr_d  = addr_aligned + XLEN'(NB);
                        p1_data_d  = data_p1;
                        p1_wmask_d = wmask_p1;
                    end
                end
            end
            ST_SECOND: begin
                if (flush_out) begin
                    state_d = ST_IDLE;
                end else if (IN_ready) begin
                    out_d.valid               = 1'b1;
                    out_d.addr                = '0;
                    out_d.addr[XLEN-1:0]      = p1_addr_q;
                    out_d.data                = '0;
                    out_d.data[XLEN-1:0]      = p1_data_q;
                    out_d.wmask               = '0;
                    out_d.wmask[NB-1:0]       = p1_wmask_q;
                    out_d.part                = 1'b1;
                    state_d                   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values computed above; the datapath fields are cleared too,
    // which keeps the output struct a single reset group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q      <= '0;
            state_q    <= ST_IDLE;
            p1_addr_q  <= '0;
            p1_data_q  <= '0;
            p1_wmask_q <= '0;
        end else begin
            out_q      <= out_d;
            state_q    <= state_d;
            p1_addr_q  <= p1_addr_d;
            p1_data_q  <= p1_data_d;
            p1_wmask_q <= p1_wmask_d;
        end
    end

endmodule

// File: tb/tb_agu_split.sv
// tb_agu_split: directed bench for agu_split (XLEN=32). A second instance with
// SPLIT_EN=0 shares the stimulus and is only inspected for the misaligned trap.
module tb_agu_split;
    import agu_split_pkg::*;

    logic         clk;
    logic         rst;
    logic         en;
    logic         in_ready;
    BranchProv    br;
    EX_UOp        uop;
    logic         out_ready, out_ready_ns;
    AGU_SPLIT_UOp out, out_ns;

    int n_total = 0;
    int n_bad   = 0;

    agu_split #(.XLEN(32), .SPLIT_EN(1), .NULL_TRAP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .IN_branch (br),
        .IN_uop    (uop),
        .OUT_ready (out_ready),
        .IN_ready  (in_ready),
        .OUT_uop   (out)
    );

    agu_split #(.XLEN(32), .SPLIT_EN(0), .NULL_TRAP(1)) dut_ns (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .IN_branch (br),
        .IN_uop    (uop),
        .OUT_ready (out_ready_ns),
        .IN_ready  (in_ready),
        .OUT_uop   (out_ns)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [63:0] addr, input logic [7:0] wmask,
                           input logic [63:0] data, input logic part, input logic split);
        check({tag, ".valid"}, 64'(out.valid), 64'd1);
        check({tag, ".addr"},  out.addr, addr);
        check({tag, ".wmask"}, 64'(out.wmask), 64'(wmask));
        check({tag, ".data"},  out.data, data);
        check({tag, ".part"},  64'(out.part), 64'(part));
        check({tag, ".split"}, 64'(out.split), 64'(split));
    endtask

    task automatic put(input lsu_op_e op, input logic [31:0] a, input logic [11:0] imm,
                       input logic [31:0] b, input logic [6:0] sqn);
        uop          = '0;
        uop.valid    = 1'b1;
        uop.opcode   = op;
        uop.srcA     = {32'h0, a};
        uop.srcB     = {32'h0, b};
        uop.imm      = imm;
        uop.sqN      = sqn;
        uop.pc       = 32'h8000_0000 + 32'(sqn);
        uop.tagDst   = 7'h11;
        uop.nmDst    = 5'h3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        en       = 1'b1;
        in_ready = 1'b1;
        br       = '0;
        uop      = '0;

        // Reset state, with a valid input present during reset.
        put(LSU_LB, 32'h10, 12'h0, 32'h0, 7'd0);
        #2;
        check("rst.ready", 64'(out_ready), 64'd0);
        check("rst.valid", 64'(out.valid), 64'd0);

        // Byte store in the top lane.
        @(negedge clk);
        rst = 1'b1;
        put(LSU_SB, 32'h1003, 12'h0, 32'hAB, 7'd1);
        #1 check("sb.ready", 64'(out_ready), 64'd1);
        tick();
        chk_out("sb", 64'h1003, 8'b1000, 64'hAB00_0000, 1'b0, 1'b0);
        check("sb.shamt", 64'(out.shamt), 64'd3);
        check("sb.exc", 64'(out.exception), 64'(EXC_NONE));
        check("sb.pc", 64'(out.pc), 64'h8000_0001);
        check("sb.isload", 64'(out.isLoad), 64'd0);

        // Crossing word store split in two; next uop waits in between.
        @(negedge clk);
        put(LSU_SW, 32'h1002, 12'h0, 32'hDDCC_BBAA, 7'd2);
        #1 check("sw.ready", 64'(out_ready), 64'd1);
        tick();
        chk_out("sw.p0", 64'h1000, 8'b1100, 64'hBBAA_0000, 1'b0, 1'b1);
        @(negedge clk);
        put(LSU_LB, 32'h3000, 12'h5, 32'h0, 7'd3);
        #1 check("sw.gap.ready", 64'(out_ready), 64'd0);
        tick();
        chk_out("sw.p1", 64'h1004, 8'b0011, 64'h0000_DDCC, 1'b1, 1'b1);
        @(negedge clk);
        #1 check("lb.ready", 64'(out_ready), 64'd1);
        tick();
        chk_out("lb", 64'h3005, 8'b0010, 64'h0, 1'b0, 1'b0);
        check("lb.isload", 64'(out.isLoad), 64'd1);
        check("lb.sext", 64'(out.signExtend), 64'd1);

        // Misaligned halfword: fine when splitting is on, trap when off.
        @(negedge clk);
        put(LSU_LH, 32'h2001, 12'h0, 32'h0, 7'd4);
        tick();
        chk_out("lh", 64'h2001, 8'b0110, 64'h0, 1'b0, 1'b0);
        check("lh.exc", 64'(out.exception), 64'(EXC_NONE));
        check("lh.ns.valid", 64'(out_ns.valid), 64'd1);
        check("lh.ns.exc", 64'(out_ns.exception), 64'(EXC_MISALIGNED));
        check("lh.ns.wmask", 64'(out_ns.wmask), 64'd0);
        check("lh.ns.split", 64'(out_ns.split), 64'd0);

        // Null pointer via negative immediate and via wrap-around.
        @(negedge clk);
        put(LSU_LW, 32'h10, 12'hFF0, 32'h0, 7'd5);
        tick();
        check("null1.addr", out.addr, 64'h0);
        check("null1.exc", 64'(out.exception), 64'(EXC_NULLPTR));
        @(negedge clk);
        put(LSU_LW, 32'hFFFF_FFFF, 12'h001, 32'h0, 7'd6);
        tick();
        check("null2.addr", out.addr, 64'h0);
        check("null2.exc", 64'(out.exception), 64'(EXC_NULLPTR));
        check("null2.split", 64'(out.split), 64'd0);

        // Doubleword on a 32-bit unit is illegal.
        @(negedge clk);
        put(LSU_LD, 32'h100, 12'h0, 32'h0, 7'd7);
        tick();
        check("ld.exc", 64'(out.exception), 64'(EXC_ILLEGAL));

        // Input younger than the branch across sqN wrap is refused.
        @(negedge clk);
        put(LSU_LB, 32'h50, 12'h0, 32'h0, 7'h01);
        br.taken = 1'b1;
        br.sqN   = 7'h7F;
        #1 check("flin.ready", 64'(out_ready), 64'd0);
        tick();
        check("flin.valid", 64'(out.valid), 64'd0);

        // Stalled part 0 flushed by an older branch: dropped, back to IDLE.
        @(negedge clk);
        br       = '0;
        in_ready = 1'b0;
        put(LSU_SW, 32'h1002, 12'h0, 32'hDDCC_BBAA, 7'd5);
        tick();
        chk_out("flout.p0", 64'h1000, 8'b1100, 64'hBBAA_0000, 1'b0, 1'b1);
        @(negedge clk);
        uop.valid = 1'b0;
        br.taken  = 1'b1;
        br.sqN    = 7'd3;
        tick();
        check("flout.valid", 64'(out.valid), 64'd0);
        @(negedge clk);
        br = '0;
        put(LSU_LB, 32'h60, 12'h0, 32'h0, 7'd8);
        #1 check("flout.idle.ready", 64'(out_ready), 64'd1);
        tick();
        chk_out("flout.next", 64'h60, 8'b0001, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        uop.valid = 1'b0;
        in_ready  = 1'b1;
        tick();
        check("flout.drain", 64'(out.valid), 64'd0);

        // Same sqN as the branch: the split survives and completes.
        @(negedge clk);
        in_ready = 1'b0;
        put(LSU_SW, 32'h1002, 12'h0, 32'hDDCC_BBAA, 7'd5);
        tick();
        @(negedge clk);
        uop.valid = 1'b0;
        br.taken  = 1'b1;
        br.sqN    = 7'd5;
        tick();
        chk_out("keep.p0", 64'h1000, 8'b1100, 64'hBBAA_0000, 1'b0, 1'b1);
        @(negedge clk);
        br       = '0;
        in_ready = 1'b1;
        tick();
        chk_out("keep.p1", 64'h1004, 8'b0011, 64'h0000_DDCC, 1'b1, 1'b1);
        @(negedge clk);
        tick();
        check("keep.drain", 64'(out.valid), 64'd0);

        // Reset pulse mid-split, then a plain byte load.
        @(negedge clk);
        put(LSU_SW, 32'h1002, 12'h0, 32'hDDCC_BBAA, 7'd6);
        tick();
        check("rs.p0.valid", 64'(out.valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rs.valid", 64'(out.valid), 64'd0);
        check("rs.ready", 64'(out_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        put(LSU_LB, 32'h40, 12'h0, 32'h12, 7'd7);
        #1 check("rs.lb.ready", 64'(out_ready), 64'd1);
        tick();
        chk_out("rs.lb", 64'h40, 8'b0001, 64'h12, 1'b0, 1'b0);
        @(negedge clk);
        uop.valid = 1'b0;
        tick();
        check("rs.idle", 64'(out.valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/agu_split.md
AGU_SPLIT -- requirements
Module: agu_split

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width (32 or 64).
REQ-002 SHALL have parameter SPLIT_EN, default 1, meaning 1 = split misaligned accesses into two aligned parts, 0 = raise a misaligned exception.
REQ-003 SHALL have parameter NULL_TRAP, default 1, meaning 1 = raise an exception on address 0.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: en  in  1  unit enable; IN_branch  in  BranchProv  branch/flush; IN_uop  in  EX_UOp  load/store uop.
REQ-006 SHALL have ports: OUT_ready  out  1  input accepted this cycle; IN_ready  in  1  downstream LSU accepts OUT_uop.
REQ-007 SHALL have port OUT_uop  out  AGU_SPLIT_UOp  result: addr[XLEN], data[XLEN], wmask[XLEN/8], shamt, size, signExtend, isLoad, part (0/1), split, exception code, plus pc, tagDst, nmDst, sqN, storeSqN, loadSqN and compressed passed through.

Function
REQ-008 SHALL compute addr = srcA + sign-extended imm[11:0], truncated to XLEN bits (wrap-around).
REQ-009 SHALL take the access size from the opcode: B=0, H=1, W/FLW/FSW=2, D=3 (XLEN=64 only; with XLEN=32, D opcodes raise an illegal-op exception).
REQ-010 SHALL register the output with one-cycle latency; an input is accepted when en, IN_uop.valid, state IDLE and (OUT_uop invalid or IN_ready), and the uop is not flushed.
REQ-011 SHALL drive OUT_ready = 1 exactly in the cycles an input is accepted.
REQ-012 SHALL hold OUT_uop stable while OUT_uop.valid && !IN_ready.
REQ-013 SHALL classify an access as misaligned when addr mod 2^size != 0.
REQ-014 SHALL classify an access as crossing when addr[low] + 2^size > XLEN/8.
REQ-015 SHALL produce a non-crossing access as one uop: wmask = ((1<<2^size)-1) << addr[low], data = srcB << 8*addr[low], shamt = addr[low], part=0, split=0.
REQ-016 SHALL, with SPLIT_EN=1, emit a crossing access as two uops over consecutive accepted output cycles.
REQ-017 SHALL build part 0 with addr aligned down, with the low mask bits and data shifted left; it SHALL build part 1 with addr aligned down + XLEN/8, the remaining mask bits and data shifted right; split=1 on both parts.
REQ-018 SHALL, with SPLIT_EN=0, set exception=MISALIGNED on a misaligned access, clear wmask and emit a single uop.
REQ-019 SHALL set exception=NULLPTR when NULL_TRAP=1 and addr==0; this has priority over MISALIGNED. A uop with an exception is never split.
REQ-020 SHALL implement the split FSM IDLE -> SECOND when part 0 of a crossing access is accepted into the output register.
REQ-021 SHALL go SECOND -> IDLE when part 1 is loaded; OUT_ready stays 0 while in SECOND.
REQ-022 SHALL treat a uop as flushed when IN_branch.taken and $signed(sqN - IN_branch.sqN) > 0.
REQ-023 SHALL not accept a flushed input, and SHALL invalidate a flushed OUT_uop in the same cycle even when it is stalled.
REQ-024 SHALL force a flushed SECOND state to IDLE with no part 1 emitted.
REQ-025 SHALL give flush priority over accept, hold and FSM advance when they occur in the same cycle.
REQ-026 SHALL leave an unflushed uop with sqN equal to IN_branch.sqN unaffected.

Reset
REQ-027 SHALL, while rst=0, asynchronously force OUT_uop.valid=0, state=IDLE, OUT_ready=0 and part-1 holding registers to 0; all other OUT_uop fields are don't-care.
REQ-028 SHALL, on reset asserted mid-split, drop part 1, and the first accept after reset release starts from IDLE.

Structure
REQ-029 SHALL place the AGU_SPLIT_UOp struct, the exception enum (NONE, NULLPTR, MISALIGNED, ILLEGAL) and the LSU opcode constants in the shared package.
REQ-030 SHALL place mask/data-shift generation in one combinational sub-module agu_lanes (size, offset, data -> wmask/data/crossing, part 0 and part 1).

Verification
REQ-031 SHALL cover: XLEN=32 SB, srcA=0x1003, imm=0, srcB=0xAB -> addr 0x1003, wmask 1000, data 0xAB000000, split=0.
REQ-032 SHALL cover: SPLIT_EN=1 SW at 0x1002, srcB=0xDDCCBBAA -> part 0 {0x1000, 1100, 0xBBAA0000}, part 1 {0x1004, 0011, 0x0000DDCC}, OUT_ready=0 in between.
REQ-033 SHALL cover: SPLIT_EN=0 LH at 0x2001 -> exception=MISALIGNED, wmask 0000.
REQ-034 SHALL cover: LW with srcA=0x10, imm=-16 -> addr 0, exception=NULLPTR; srcA=0xFFFFFFFF, imm=1 -> wrap to 0 -> NULLPTR.
REQ-035 SHALL cover: IN_ready=0 holding part 0 of sqN=5, then branch taken with sqN=3 -> OUT_uop.valid=0 next edge, state IDLE, no part 1; repeat with branch sqN=5 -> uop survives.
REQ-036 SHALL cover: rst pulsed low mid-split -> valid=0 immediately, then a normal LB completes in 1 cycle.
